// File: rtl/ex_hilo_div.sv
// ex_hilo_div: execute stage with HI/LO registers and a 1-bit-per-cycle
// restoring divider. The writeback triple is combinational, so decode can
// forward from it in the same cycle. stallreq_o holds upstream while a
// divide is in flight.
// Optional feature macro: EX_MULT_EN (single-cycle MULT/MULTU into HI/LO).
module ex_hilo_div #(
  parameter int          DIV_ITER = 32,
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic        flush_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [7:0] OP_AND   = 8'h24;
  localparam logic [7:0] OP_OR    = 8'h25;
  localparam logic [7:0] OP_XOR   = 8'h26;
  localparam logic [7:0] OP_NOR   = 8'h27;
  localparam logic [7:0] OP_SLL   = 8'h7C;
  localparam logic [7:0] OP_SRL   = 8'h02;
  localparam logic [7:0] OP_SRA   = 8'h03;
  localparam logic [7:0] OP_ADDU  = 8'h21;
  localparam logic [7:0] OP_SUBU  = 8'h23;
  localparam logic [7:0] OP_SLT   = 8'h2A;
  localparam logic [7:0] OP_SLTU  = 8'h2B;
  localparam logic [7:0] OP_MFHI  = 8'h10;
  localparam logic [7:0] OP_MTHI  = 8'h11;
  localparam logic [7:0] OP_MFLO  = 8'h12;
  localparam logic [7:0] OP_MTLO  = 8'h13;
  localparam logic [7:0] OP_DIV   = 8'h1A;
  localparam logic [7:0] OP_DIVU  = 8'h1B;
`ifdef EX_MULT_EN
  localparam logic [7:0] OP_MULT  = 8'h18;
  localparam logic [7:0] OP_MULTU = 8'h19;
`endif

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  localparam int             CNT_W    = $clog2(DIV_ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DZERO = 2'd2,
    S_DONE  = 2'd3
  } div_state_t;

  div_state_t       state_r, state_nxt_s;
  logic [31:0]      hi_r, lo_r;
  logic [31:0]      rem_r, quo_r, dsr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             neg_q_r, neg_r_r;
  logic             is_div_s, div_signed_s, stall_s;
  logic [32:0]      rem_sh_s, diff_s;
  logic [31:0]      q_fix_s, r_fix_s, result_s;

  // two's-complement negate
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return (~v) + 32'd1;
  endfunction

  // magnitude of a signed 32-bit value (0x80000000 maps to 2^31 unsigned)
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  assign is_div_s     = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
  assign div_signed_s = (aluop_i == OP_DIV);

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract. Since rem < divisor, the shifted value is below
  // 2*divisor, so bit 32 of the 33-bit difference is the borrow.
  assign rem_sh_s = {rem_r, quo_r[31]};
  assign diff_s   = rem_sh_s - {1'b0, dsr_r};

  assign q_fix_s = neg_q_r ? neg32(quo_r) : quo_r;
  assign r_fix_s = neg_r_r ? neg32(rem_r) : rem_r;

`ifdef EX_MULT_EN
  logic [63:0] mult_s_s, mult_u_s;
  assign mult_s_s = $unsigned($signed({{32{reg1_i[31]}}, reg1_i}) *
                              $signed({{32{reg2_i[31]}}, reg2_i}));
  assign mult_u_s = {32'h0, reg1_i} * {32'h0, reg2_i};
`endif

  // divider state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // divider next-state and stall request; flush wins over everything
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    if (flush_i) begin
      state_nxt_s = S_IDLE;
      stall_s     = 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (is_div_s) begin
            stall_s = 1'b1;
            if (reg2_i == 32'h0) begin
              state_nxt_s = S_DZERO;
            end else begin
              state_nxt_s = S_BUSY;
            end
          end else begin
            state_nxt_s = S_IDLE;
          end
        end
        S_BUSY: begin
          stall_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_BUSY;
          end
        end
        S_DZERO: begin
          stall_s     = 1'b1;
          state_nxt_s = S_DONE;
        end
        S_DONE: begin
          stall_s     = 1'b0;
          state_nxt_s = S_IDLE;
        end
        default: begin
          stall_s     = 1'b0;
          state_nxt_s = S_IDLE;
        end
      endcase
    end
  end

  // divider datapath: latch operands on entry, then one quotient bit per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_r   <= 32'h0;
      quo_r   <= 32'h0;
      dsr_r   <= 32'h0;
      cnt_r   <= CNT_ZERO;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (is_div_s && !flush_i) begin
            rem_r   <= 32'h0;
            cnt_r   <= CNT_ZERO;
            quo_r   <= div_signed_s ? abs32(reg1_i) : reg1_i;
            dsr_r   <= div_signed_s ? abs32(reg2_i) : reg2_i;
            neg_q_r <= div_signed_s && (reg1_i[31] ^ reg2_i[31]);
            neg_r_r <= div_signed_s && reg1_i[31];
          end
        end
        S_BUSY: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (!diff_s[32]) begin
            rem_r <= diff_s[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
          end else begin
            rem_r <= rem_sh_s[31:0];
            quo_r <= {quo_r[30:0], 1'b0};
          end
        end
        S_DZERO: begin
          rem_r <= 32'h0;
          quo_r <= 32'h0;
        end
        default: begin
          rem_r <= rem_r;
        end
      endcase
    end
  end

  // HI/LO update: divide result at the DONE edge, else moves (and multiplies)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= HILO_RST;
      lo_r <= HILO_RST;
    end else if (flush_i) begin
      hi_r <= hi_r;
    end else if (state_r == S_DONE) begin
      hi_r <= r_fix_s;
      lo_r <= q_fix_s;
    end else if (aluop_i == OP_MTHI) begin
      hi_r <= reg1_i;
    end else if (aluop_i == OP_MTLO) begin
      lo_r <= reg1_i;
`ifdef EX_MULT_EN
    end else if (aluop_i == OP_MULT) begin
      hi_r <= mult_s_s[63:32];
      lo_r <= mult_s_s[31:0];
    end else if (aluop_i == OP_MULTU) begin
      hi_r <= mult_u_s[63:32];
      lo_r <= mult_u_s[31:0];
`endif
    end else begin
      hi_r <= hi_r;
    end
  end

  // GPR result selection by result class, unknown codes give zero
  always_comb begin
    result_s = 32'h0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_OR:   result_s = reg1_i | reg2_i;
          OP_AND:  result_s = reg1_i & reg2_i;
          OP_XOR:  result_s = reg1_i ^ reg2_i;
          OP_NOR:  result_s = ~(reg1_i | reg2_i);
          default: result_s = 32'h0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  result_s = reg2_i << reg1_i[4:0];
          OP_SRL:  result_s = reg2_i >> reg1_i[4:0];
          OP_SRA:  result_s = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
          default: result_s = 32'h0;
        endcase
      end
      SEL_MOVE: begin
        case (aluop_i)
          OP_MFHI: result_s = hi_r;
          OP_MFLO: result_s = lo_r;
          default: result_s = 32'h0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADDU: result_s = reg1_i + reg2_i;
          OP_SUBU: result_s = reg1_i - reg2_i;
          OP_SLT:  result_s = ($signed(reg1_i) < $signed(reg2_i)) ? 32'd1 : 32'd0;
          OP_SLTU: result_s = (reg1_i < reg2_i) ? 32'd1 : 32'd0;
          default: result_s = 32'h0;
        endcase
      end
      default: result_s = 32'h0;
    endcase
  end

  // writeback triple and stall, forced quiet while reset is asserted
  always_comb begin
    wd_o       = 5'd0;
    wreg_o     = 1'b0;
    wdata_o    = 32'h0;
    stallreq_o = 1'b0;
    if (rst) begin
      wd_o       = 5'd0;
      wreg_o     = 1'b0;
      wdata_o    = 32'h0;
      stallreq_o = 1'b0;
    end else begin
      wd_o       = wd_i;
      wreg_o     = wreg_i;
      wdata_o    = result_s;
      stallreq_o = stall_s;
    end
  end

  assign hi_o = hi_r;
  assign lo_o = lo_r;

endmodule

// File: tb/tb_ex_hilo_div.sv
// Bench for ex_hilo_div: directed vectors with literal expectations plus a
// cycle-level behavioural model checked every negative clock edge.
module tb_ex_hilo_div;

  localparam logic [31:0] HILO_RST = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  aluop = 8'h0;
  logic [2:0]  alusel = 3'd0;
  logic [31:0] reg1 = 32'h0, reg2 = 32'h0;
  logic [4:0]  wd = 5'd0;
  logic        wreg = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  wd_out;
  logic        wreg_out, stall_out;
  logic [31:0] wdata_out, hi_out, lo_out;

  int n_cmp = 0;
  int n_bad = 0;

  ex_hilo_div #(.DIV_ITER(32), .HILO_RST(HILO_RST)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .flush_i(flush),
    .wd_o(wd_out), .wreg_o(wreg_out), .wdata_o(wdata_out),
    .stallreq_o(stall_out), .hi_o(hi_out), .lo_o(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_hi = HILO_RST, m_lo = HILO_RST;
  logic [31:0] m_q = 32'h0, m_r = 32'h0;
  int          m_age = -1;   // cycles since the divide entered, -1 when none
  int          m_len = 0;    // cycle index of the closing (DONE) cycle

  function automatic logic is_div(input logic [7:0] op);
    return (op == 8'h1A) || (op == 8'h1B);
  endfunction

  // {remainder, quotient} by plain 64-bit arithmetic (truncating division)
  function automatic logic [63:0] div_model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (op == 8'h1A) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] hi, input logic [31:0] lo);
    logic signed [63:0] sa, sb, sh;
    logic [31:0] res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sh = sb >>> a[4:0];
    res = 32'h0;
    case (sel)
      3'd1: case (op)
              8'h25: res = a | b;
              8'h24: res = a & b;
              8'h26: res = a ^ b;
              8'h27: res = ~(a | b);
              default: res = 32'h0;
            endcase
      3'd2: case (op)
              8'h7C: res = b << a[4:0];
              8'h02: res = b >> a[4:0];
              8'h03: res = sh[31:0];
              default: res = 32'h0;
            endcase
      3'd3: case (op)
              8'h10: res = hi;
              8'h12: res = lo;
              default: res = 32'h0;
            endcase
      3'd4: case (op)
              8'h21: res = a + b;
              8'h23: res = a - b;
              8'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
              8'h2B: res = ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
              default: res = 32'h0;
            endcase
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  // model state advance at each rising edge
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hi  <= HILO_RST;
      m_lo  <= HILO_RST;
      m_age <= -1;
    end else if (flush) begin
      m_age <= -1;
    end else if (m_age < 0) begin
      if (is_div(aluop)) begin
        m_age <= 1;
        m_len <= (reg2 == 32'h0) ? 2 : 33;
        {m_r, m_q} <= div_model(aluop, reg1, reg2);
      end else if (aluop == 8'h11) begin
        m_hi <= reg1;
      end else if (aluop == 8'h13) begin
        m_lo <= reg1;
`ifdef EX_MULT_EN
      end else if (aluop == 8'h18) begin
        {m_hi, m_lo} <= {{32{reg1[31]}}, reg1} * {{32{reg2[31]}}, reg2};
      end else if (aluop == 8'h19) begin
        {m_hi, m_lo} <= {32'h0, reg1} * {32'h0, reg2};
`endif
      end
    end else if (m_age == m_len) begin
      m_hi  <= m_r;
      m_lo  <= m_q;
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    logic e_stall;
    if (rst) begin
      check("m_wdata", wdata_out, 32'h0);
      check("m_wd", {27'h0, wd_out}, 32'h0);
      check("m_wreg", {31'h0, wreg_out}, 32'h0);
      check("m_stall", {31'h0, stall_out}, 32'h0);
      check("m_hi", hi_out, HILO_RST);
      check("m_lo", lo_out, HILO_RST);
    end else begin
      if (flush) e_stall = 1'b0;
      else if (m_age < 0) e_stall = is_div(aluop);
      else e_stall = (m_age < m_len);
      check("m_wdata", wdata_out, exp_wdata(aluop, alusel, reg1, reg2, m_hi, m_lo));
      check("m_wd", {27'h0, wd_out}, {27'h0, wd});
      check("m_wreg", {31'h0, wreg_out}, {31'h0, wreg});
      check("m_stall", {31'h0, stall_out}, {31'h0, e_stall});
      check("m_hi", hi_out, m_hi);
      check("m_lo", lo_out, m_lo);
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d, input logic w);
    aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // issue a divide, count stalled cycles, hold through DONE, then go NOP
  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
    drive(op, 3'd0, a, b, 5'd0, 1'b0);
    #1;
    stalls = 0;
    while (stall_out && stalls < 100) begin
      stalls++;
      step();
    end
    step();
    drive(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  initial begin
    int st;
    vecs[0]  = '{8'h25, 3'd1, 32'h0000_1100, 32'h0000_0011, 32'h0000_1111};
    vecs[1]  = '{8'h24, 3'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[2]  = '{8'h26, 3'd1, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
    vecs[3]  = '{8'h27, 3'd1, 32'h0000_FFFF, 32'h00FF_0000, 32'hFF00_0000};
    vecs[4]  = '{8'h7C, 3'd2, 32'h0000_0004, 32'h0000_0013, 32'h0000_0130};
    vecs[5]  = '{8'h02, 3'd2, 32'h0000_0008, 32'h8000_0000, 32'h0080_0000};
    vecs[6]  = '{8'h03, 3'd2, 32'h0000_0008, 32'h8000_0000, 32'hFF80_0000};
    vecs[7]  = '{8'h03, 3'd2, 32'h0000_0021, 32'h8000_0000, 32'hC000_0000};
    vecs[8]  = '{8'h21, 3'd4, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[9]  = '{8'h23, 3'd4, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[10] = '{8'h2A, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[11] = '{8'h2B, 3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[12] = '{8'h25, 3'd7, 32'h0000_1100, 32'h0000_0011, 32'h0000_0000};
    vecs[13] = '{8'h21, 3'd1, 32'h0000_1100, 32'h0000_0011, 32'h0000_0000};
    vecs[14] = '{8'h11, 3'd3, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};

    // reset: outputs forced quiet even with a live instruction on the inputs
    drive(8'h25, 3'd1, 32'h0000_1100, 32'h0000_0011, 5'd5, 1'b1);
    step();
    check("rst_wdata", wdata_out, 32'h0);
    check("rst_wreg", {31'h0, wreg_out}, 32'h0);
    check("rst_wd", {27'h0, wd_out}, 32'h0);
    check("rst_hi", hi_out, 32'h0);
    rst = 1'b0;
    #1;
    check("ori_wdata", wdata_out, 32'h0000_1111);
    check("ori_wd", {27'h0, wd_out}, 32'd5);
    check("ori_wreg", {31'h0, wreg_out}, 32'd1);
    step();

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].op, vecs[i].sel, vecs[i].a, vecs[i].b, 5'(i + 1), 1'b1);
      #1;
      check($sformatf("vec%0d_wdata", i), wdata_out, vecs[i].exp);
      step();
    end
    check("mthi_hi", hi_out, 32'h1234_5678);

    do_div(8'h1B, 32'd100, 32'd7, st);
    check("divu_stalls", 32'(st), 32'd33);
    check("divu_lo", lo_out, 32'd14);
    check("divu_hi", hi_out, 32'd2);

    do_div(8'h1A, 32'h8000_0000, 32'hFFFF_FFFF, st);
    check("ovf_lo", lo_out, 32'h8000_0000);
    check("ovf_hi", hi_out, 32'h0);

    do_div(8'h1A, 32'hFFFF_FFF9, 32'd2, st);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    check("div_hi", hi_out, 32'hFFFF_FFFF);
    drive(8'h12, 3'd3, 32'h0, 32'h0, 5'd9, 1'b1);
    #1;
    check("mflo_wdata", wdata_out, 32'hFFFF_FFFD);
    step();

    do_div(8'h1A, 32'd10, 32'd0, st);
    check("dz_stalls", 32'(st), 32'd2);
    check("dz_lo", lo_out, 32'h0);
    check("dz_hi", hi_out, 32'h0);

    drive(8'h19, 3'd0, 32'h0001_0000, 32'h0001_0000, 5'd0, 1'b0);
    #1;
    check("multu_stall", {31'h0, stall_out}, 32'h0);
    step();
`ifdef EX_MULT_EN
    check("multu_hi", hi_out, 32'h1);
`else
    check("multu_hi", hi_out, 32'h0);
`endif
    check("multu_lo", lo_out, 32'h0);

    // flush mid-divide keeps HI/LO and returns the divider to idle
    drive(8'h11, 3'd3, 32'hA5A5_A5A5, 32'h0, 5'd0, 1'b0);
    step();
    drive(8'h1B, 3'd0, 32'd100, 32'd7, 5'd0, 1'b0);
    repeat (10) step();
    flush = 1'b1;
    #1;
    check("flush_stall", {31'h0, stall_out}, 32'h0);
    step();
    flush = 1'b0;
    drive(8'h10, 3'd3, 32'h0, 32'h0, 5'd4, 1'b1);
    #1;
    check("flush_idle_stall", {31'h0, stall_out}, 32'h0);
    check("flush_hi", hi_out, 32'hA5A5_A5A5);
    check("mfhi_wdata", wdata_out, 32'hA5A5_A5A5);
    step();

    // asynchronous reset in the middle of a divide
    drive(8'h1B, 3'd0, 32'd100, 32'd7, 5'd0, 1'b0);
    repeat (5) step();
    #2;
    rst = 1'b1;
    drive(8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0);
    #1;
    check("arst_stall", {31'h0, stall_out}, 32'h0);
    check("arst_hi", hi_out, HILO_RST);
    check("arst_lo", lo_out, HILO_RST);
    @(negedge clk);
    #2;
    rst = 1'b0;
    step();
    do_div(8'h1B, 32'd9, 32'd3, st);
    check("post_rst_stalls", 32'(st), 32'd33);
    check("post_rst_lo", lo_out, 32'd3);
    check("post_rst_hi", hi_out, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
